// File: rtl/tiny45_mem_arbiter.sv
// Shares one halfword memory port between the instruction-fetch streamer and
// the 32-bit data path; data accesses preempt fetch and run as two beats.
module tiny45_mem_arbiter #(
  parameter int ADDR_BITS = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [22:0]          instr_addr,
  input  logic                 instr_fetch_restart,
  input  logic                 instr_fetch_stall,
  output logic                 instr_fetch_started,
  output logic                 instr_fetch_stopped,
  output logic [15:0]          instr_data_in,
  output logic                 instr_ready,
  input  logic [ADDR_BITS-1:0] data_addr,
  input  logic                 data_write,
  input  logic                 data_read,
  input  logic [31:0]          data_out,
  output logic                 data_ready,
  output logic [31:0]          data_in,
  output logic                 mem_valid,
  output logic                 mem_we,
  output logic [ADDR_BITS-2:0] mem_addr,
  output logic [15:0]          mem_wdata,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DATA_LO = 2'd2,
    S_DATA_HI = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   pending_q;
  logic                   pending_we_q;
  logic [ADDR_BITS-1:2]   addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            data_in_q;
  logic                   started_q;
  logic                   stopped_q;
  logic                   data_ready_q;

  logic req_new;
  logic data_due;
  logic beat_done;
  logic unused_addr_lsbs;

  // Word accesses only: the byte-lane bits of the data address carry no meaning.
  assign unused_addr_lsbs = &{1'b0, data_addr[1:0]};

  // A pulse arriving while an access is outstanding is dropped.
  assign req_new   = (data_read | data_write) & ~pending_q;
  assign data_due  = pending_q | req_new;
  assign beat_done = mem_valid & mem_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      pending_we_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_in_q    <= '0;
      started_q    <= 1'b0;
      stopped_q    <= 1'b0;
      data_ready_q <= 1'b0;
    end else begin
      started_q    <= 1'b0;
      stopped_q    <= 1'b0;
      data_ready_q <= 1'b0;

      if (req_new) begin
        pending_q    <= 1'b1;
        pending_we_q <= data_write;
        addr_q       <= data_addr[ADDR_BITS-1:2];
        wdata_q      <= data_out;
      end

      case (state_q)
        S_IDLE: begin
          if (data_due) begin
            state_q <= S_DATA_LO;
          end else if (instr_fetch_restart) begin
            state_q   <= S_FETCH;
            started_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (data_due) begin
            state_q   <= S_DATA_LO;
            stopped_q <= 1'b1;
          end else if (instr_fetch_restart) begin
            state_q   <= S_IDLE;
            stopped_q <= 1'b1;
          end
        end
        S_DATA_LO: begin
          if (beat_done) begin
            if (!pending_we_q) data_in_q[15:0] <= mem_rdata;
            state_q <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (beat_done) begin
            if (!pending_we_q) data_in_q[31:16] <= mem_rdata;
            pending_q    <= 1'b0;
            data_ready_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port drive is decoded from state so a stall release issues a beat at once.
  always_comb begin
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        mem_valid = ~instr_fetch_stall & ~instr_fetch_restart & ~pending_q;
        mem_addr  = (ADDR_BITS-1)'(instr_addr);
      end
      S_DATA_LO: begin
        mem_valid = 1'b1;
        mem_we    = pending_we_q;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = wdata_q[15:0];
      end
      S_DATA_HI: begin
        mem_valid = 1'b1;
        mem_we    = pending_we_q;
        mem_addr  = {addr_q, 1'b1};
        mem_wdata = wdata_q[31:16];
      end
      default: ;
    endcase
  end

  assign instr_ready         = (state_q == S_FETCH) & mem_valid & mem_ready;
  assign instr_data_in       = mem_rdata;
  assign instr_fetch_started = started_q;
  assign instr_fetch_stopped = stopped_q;
  assign data_ready          = data_ready_q;
  assign data_in             = data_in_q;

endmodule

// File: doc/tiny45_mem_arbiter.md
Name: tiny45_mem_arbiter

Overview:
Shares one halfword-wide memory port between the CPU instruction-fetch streamer and its 32-bit data load/store path. Data accesses have priority and preempt fetch at a halfword-beat boundary; fetch is restarted afterwards via the started/stopped handshake. Sits between tiny45_cpu and the QSPI/memory controller.

Parameters:
ADDR_BITS, 28, width of the memory-port byte address (mem_addr carries bits ADDR_BITS-1:1).

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous active-low reset.
instr_addr  in  23  halfword fetch address (bits 23:1); zero-extended onto mem_addr.
instr_fetch_restart  in  1  CPU requests that the fetch stream (re)start at instr_addr.
instr_fetch_stall  in  1  CPU buffer full; no fetch beat may be issued.
instr_fetch_started  out  1  one-cycle pulse: fetch stream now running.
instr_fetch_stopped  out  1  one-cycle pulse: fetch stream halted by the arbiter.
instr_data_in  out  16  fetched halfword (combinational copy of mem_rdata).
instr_ready  out  1  fetch beat accepted this cycle.
data_addr  in  28  data byte address; bits 1:0 ignored (word access).
data_write  in  1  one-cycle store request pulse.
data_read  in  1  one-cycle load request pulse.
data_out  in  32  store data, sampled with data_write.
data_ready  out  1  one-cycle pulse: data access complete.
data_in  out  32  load result, registered; valid when data_ready is high.
mem_valid  out  1  beat request.
mem_we  out  1  beat is a write.
mem_addr  out  ADDR_BITS-1  halfword address.
mem_wdata  out  16  write halfword.
mem_rdata  in  16  read halfword, valid when mem_valid && mem_ready.
mem_ready  in  1  beat completes when mem_valid && mem_ready.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; mem_valid, mem_we, instr_fetch_started, instr_fetch_stopped, data_ready = 0; data_in = 0; pending = 0; mem_addr and mem_wdata = 0.
- Data capture: data_read or data_write latches pending=1, pending_we=data_write, the address, and data_out. A second pulse while pending is set or a data access is in progress is dropped; this is a protocol violation the bench flags. If both pulses arrive together, the access is treated as a write.
- States: IDLE, FETCH, DATA_LO, DATA_HI.
- IDLE:
  - pending set -> DATA_LO next cycle.
  - Otherwise, instr_fetch_restart set -> FETCH, with instr_fetch_started pulsed in that same transition cycle.
  - mem_valid = 0.
- FETCH:
  - mem_valid = !instr_fetch_stall && !instr_fetch_restart && !pending.
  - mem_we = 0; mem_addr = instr_addr.
  - instr_ready = mem_valid && mem_ready.
  - pending set -> DATA_LO next cycle; pulse instr_fetch_stopped. No new beat is issued in the cycle pending is visible. A beat completing in the same cycle as the request pulse is still delivered.
  - instr_fetch_restart with no pending -> IDLE (branch); pulse instr_fetch_stopped. Fetch then re-enters via IDLE one cycle later at the new instr_addr.
- DATA_LO:
  - mem_valid = 1; mem_addr = {addr[27:2], 0}; mem_we = pending_we; mem_wdata = data_out[15:0].
  - On beat completion: capture data_in[15:0] from mem_rdata (reads only), then -> DATA_HI.
- DATA_HI:
  - As DATA_LO, but mem_addr has bit 1 set and mem_wdata = data_out[31:16]; reads capture data_in[31:16].
  - On completion: pending cleared; data_ready pulses the next cycle; -> IDLE.
- Latency, zero-wait memory: request pulse at cycle N -> DATA_LO at N+1 -> DATA_HI at N+2 -> data_ready at N+3. The earliest fetch restart is N+4 (IDLE sees instr_fetch_restart).
- Writes leave data_in unchanged.
- Address outputs are held stable while mem_valid is high and mem_ready is low. The exception is FETCH, where mem_addr follows instr_addr, which the CPU keeps stable while no beat completes.
- instr_fetch_started and instr_fetch_stopped are never high in the same cycle.
- instr_ready is never high outside FETCH.

Test Plan:
1. Reset release, instr_fetch_restart=1, instr_addr=0x000100, zero-wait memory -> started pulses once. mem_addr is 0x000100, 0x000101, ... on successive cycles and instr_ready is high every cycle.
2. During streaming, pulse data_read at data_addr=0x0000408 -> instr_fetch_stopped pulses. Beats go to 0x204 then 0x205 with mem_we=0. With mem_rdata 0x5678 then 0x1234, data_in=0x12345678 and data_ready pulses 3 cycles after the request; fetch restarts afterwards.
3. Pulse data_write, data_addr=0x1000000, data_out=0xCAFEF00D -> two beats with mem_we=1, mem_addr 0x800000 then 0x800001, mem_wdata 0xF00D then 0xCAFE. data_ready pulses and data_in is unchanged.
4. Hold instr_fetch_stall=1 in FETCH -> mem_valid=0 and no instr_ready. Deassert it -> a beat is issued the same cycle.
5. instr_fetch_restart pulsed mid-stream (branch to 0x000400) -> stopped pulse, IDLE for one cycle, started pulse, next beat at 0x000400.
6. mem_ready held low for 5 cycles in DATA_LO, then assert rstn=0 -> mem_valid drops immediately. After release: no data_ready, pending cleared, state IDLE.
